// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between two requesters.
// One transaction in flight, with a per-transaction timeout.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            aCommand,
  input  logic [ADDR_WIDTH-1:0] aAddress,
  input  logic [DATA_WIDTH-1:0] aData,
  output logic                  aDone,
  output logic [DATA_WIDTH-1:0] aRdata,
  output logic                  aError,
  input  logic [2:0]            bCommand,
  input  logic [ADDR_WIDTH-1:0] bAddress,
  input  logic [DATA_WIDTH-1:0] bData,
  output logic                  bDone,
  output logic [DATA_WIDTH-1:0] bRdata,
  output logic                  bError,
  output logic [2:0]            cCommand,
  output logic [ADDR_WIDTH-1:0] cAddress,
  output logic [DATA_WIDTH-1:0] cData,
  input  logic                  hReady,
  input  logic                  hSignal,
  input  logic [DATA_WIDTH-1:0] hData
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  side_q, side_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic a_req, b_req, win_b;
  logic busy, done_a, done_b;

  assign a_req = |aCommand;
  assign b_req = |bCommand;
  // ptr_q=1 means B has priority on a tie
  assign win_b = b_req && (!a_req || ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    side_d  = side_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (hReady && (a_req || b_req)) begin
          side_d  = win_b;
          cmd_d   = win_b ? bCommand : aCommand;
          addr_d  = win_b ? bAddress : aAddress;
          data_d  = win_b ? bData : aData;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
        if (hSignal) begin
          rdata_d = hData;
          err_d   = 1'b0;
          ptr_d   = ~side_q;
          state_d = DONE;
        end else if (cnt_q == CLAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ptr_d   = ~side_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      side_q  <= 1'b0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus and result outputs are gated by state so reset clears them at once
  assign busy   = (state_q == BUSY);
  assign done_a = (state_q == DONE) && !side_q;
  assign done_b = (state_q == DONE) && side_q;

  assign cCommand = busy ? cmd_q : '0;
  assign cAddress = busy ? addr_q : '0;
  assign cData    = busy ? data_q : '0;

  assign aDone  = done_a;
  assign aRdata = done_a ? rdata_q : '0;
  assign aError = done_a && err_q;
  assign bDone  = done_b;
  assign bRdata = done_b ? rdata_q : '0;
  assign bError = done_b && err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter.
// Reference model tracks bus phases, requester holds and fairness.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    aCommand = '0;
  logic [AW-1:0] aAddress = '0;
  logic [DW-1:0] aData = '0;
  logic [2:0]    bCommand = '0;
  logic [AW-1:0] bAddress = '0;
  logic [DW-1:0] bData = '0;
  logic          hReady = 1'b0;
  logic          hSignal = 1'b0;
  logic [DW-1:0] hData = '0;
  logic          aDone, aError, bDone, bError;
  logic [DW-1:0] aRdata, bRdata, cData;
  logic [2:0]    cCommand;
  logic [AW-1:0] cAddress;

  mem_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .aCommand(aCommand),
    .aAddress(aAddress),
    .aData(aData),
    .aDone(aDone),
    .aRdata(aRdata),
    .aError(aError),
    .bCommand(bCommand),
    .bAddress(bAddress),
    .bData(bData),
    .bDone(bDone),
    .bRdata(bRdata),
    .bError(bError),
    .cCommand(cCommand),
    .cAddress(cAddress),
    .cData(cData),
    .hReady(hReady),
    .hSignal(hSignal),
    .hData(hData)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            side;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: 0 = bus free, 1 = transaction in flight, 2 = result cycle
  int            m_st = 0;
  bit            m_ptr = 1'b0;
  bit            m_side = 1'b0;
  int            m_bcnt = 0;
  int            m_lat = 0;
  logic [2:0]    m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rsp;
  int            stall = 0;
  bit            quiesce = 1'b0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step_model();
    bit   w;
    exp_t ne;
    case (m_st)
      0: begin
        if (hReady && (aCommand != 0 || bCommand != 0)) begin
          w      = (bCommand != 0) && (aCommand == 0 || m_ptr);
          m_side = w;
          m_cmd  = w ? bCommand : aCommand;
          m_addr = w ? bAddress : aAddress;
          m_data = w ? bData : aData;
          chk("grant_bus", {cCommand, cAddress, cData},
              {m_cmd, m_addr, m_data});
          case ($urandom_range(0, 7))
            0: m_lat = TO;
            1: m_lat = TO + 5;
            default: m_lat = $urandom_range(1, TO - 1);
          endcase
          m_rsp  = $urandom;
          m_bcnt = 1;
          m_st   = 1;
          ne.side  = w;
          ne.rdata = (m_lat <= TO) ? m_rsp : '0;
          ne.err   = (m_lat > TO);
          sb.push_back(ne);
        end else begin
          chk("idle_cmd", cCommand, 0);
        end
      end
      1: begin
        if (m_bcnt == m_lat || m_bcnt == TO) begin
          m_st  = 2;
          m_ptr = !m_side;
          chk("end_cmd", cCommand, 0);
        end else begin
          m_bcnt++;
          chk("hold_bus", {cCommand, cAddress, cData},
              {m_cmd, m_addr, m_data});
        end
      end
      default: begin
        m_st = 0;
        chk("after_done_cmd", cCommand, 0);
      end
    endcase
    chk("aDone_time", aDone, m_st == 2 && !m_side);
    chk("bDone_time", bDone, m_st == 2 && m_side);
    if (m_st != 2)
      chk("quiet_outs", {aRdata, aError, bRdata, bError}, 0);
  endtask

  task automatic drive();
    if (stall > 0) begin
      stall--;
      hReady = 1'b0;
    end else if ($urandom_range(0, 49) == 0) begin
      stall  = 10;
      hReady = 1'b0;
    end else begin
      hReady = ($urandom_range(0, 3) != 0);
    end
    if (m_st == 1 && m_bcnt == m_lat) begin
      hSignal = 1'b1;
      hData   = m_rsp;
    end else begin
      hSignal = (m_st != 1) && ($urandom_range(0, 7) == 0);
      hData   = $urandom;
    end
    if (aCommand != 0) begin
      if (m_st == 2 && !m_side) aCommand = '0;
    end
    if (aCommand == 0 && !quiesce && $urandom_range(0, 2) == 0) begin
      aCommand = 3'($urandom_range(1, 7));
      aAddress = $urandom;
      aData    = $urandom;
    end
    if (bCommand != 0) begin
      if (m_st == 2 && m_side) bCommand = '0;
    end
    if (bCommand == 0 && !quiesce && $urandom_range(0, 2) == 0) begin
      bCommand = 3'($urandom_range(1, 7));
      bAddress = $urandom;
      bData    = $urandom;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && (aDone || bDone)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: done=%b%b want no completion",
                 aDone, bDone);
      end else begin
        e = sb.pop_front();
        chk("done_pair", {aDone, bDone}, {!e.side, e.side});
        chk("done_rdata", e.side ? bRdata : aRdata, e.rdata);
        chk("done_err", e.side ? bError : aError, e.err);
      end
    end
  end

  initial begin
    bit rst_hold = 1'b0;
    int n_rst = 0;
    bit idle_ok = 1'b0;
    #3;
    chk("rst_bus", {cCommand, cAddress, cData}, 0);
    chk("rst_done", {aDone, bDone, aError, bError}, 0);
    chk("rst_rdata", {aRdata, bRdata}, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (rst_hold) begin
        chk("rst_hold_cmd", cCommand, 0);
        chk("rst_hold_done", {aDone, bDone}, 0);
        reset    = 1'b1;
        rst_hold = 1'b0;
      end else begin
        step_model();
      end
      drive();
      if (m_st == 1 && m_bcnt == 2 &&
          ((cyc > 300 && n_rst == 0) ||
           (cyc > 1500 && n_rst == 1))) begin
        #2 reset = 1'b0;
        #1;
        chk("async_rst_cmd", cCommand, 0);
        chk("async_rst_bus", {cAddress, cData}, 0);
        void'(sb.pop_back());
        m_st     = 0;
        m_ptr    = 1'b0;
        rst_hold = 1'b1;
        n_rst++;
      end
    end
    quiesce = 1'b1;
    for (int i = 0; i < 200 && !idle_ok; i++) begin
      @(negedge clock);
      step_model();
      drive();
      idle_ok = (m_st == 0) && (aCommand == 0) && (bCommand == 0);
    end
    chk("drain_done", idle_ok, 1);
    @(negedge clock);
    @(negedge clock);
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
